// File: rtl/cpu_pkg.sv
// +-----------------------------------------------------------------------------+
// | cpu_pkg : shared opcode constants, pcsrc encodings and flush counter sizing |
// | rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
`default_nettype none

package cpu_pkg;

  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;

  typedef enum logic [1:0] {
    PCSRC_SEQ  = 2'b00,
    PCSRC_HOLD = 2'b01,
    PCSRC_EX   = 2'b10,
    PCSRC_JMP  = 2'b11
  } pcsrc_t;

  // Wide enough for the largest legal flush depth (7).
  localparam int FLUSH_CW = 3;

endpackage

`default_nettype wire

// File: rtl/pc_flush_ctr.sv
// +-----------------------------------------------------------------------------+
// | pc_flush_ctr : squash-cycle counter, reloads on load, counts down on dec    |
// | rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
`default_nettype none

module pc_flush_ctr
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic busy
);

  logic [FLUSH_CW-1:0] r_cnt;

  // A load always restarts the full window rather than adding to it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= FLUSH_CW'(DEPTH);
    end else if (dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign busy = (r_cnt != '0);

endmodule

`default_nettype wire

// File: rtl/pc_sequencer.sv
// +-----------------------------------------------------------------------------+
// | pc_sequencer : next-PC selection, EX redirect / ID jump, squash control     |
// | optional PC_REDIR_CNT_EN adds a saturating redirect counter; rev 1.0        |
// +-----------------------------------------------------------------------------+
`default_nettype none

module pc_sequencer
  import cpu_pkg::*;
#(
  parameter int          AW          = 32,
  parameter int          FLUSH_DEPTH = 2,
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic [5:0]    id_op,
  input  logic [25:0]   id_jaddr,
  input  logic [5:0]    ex_op,
  input  logic          ex_zero,
  input  logic          ex_jr,
  input  logic [AW-1:0] ex_btarget,
  input  logic [AW-1:0] ex_jrtarget,
  output logic [AW-1:0] pc,
  output logic [AW-1:0] pc_plus4,
  output logic [1:0]    pcsrc,
`ifdef PC_REDIR_CNT_EN
  output logic          condep,
  output logic [15:0]   redir_cnt
`else
  output logic          condep
`endif
);

  logic [AW-1:0] r_pc;
  logic [AW-1:0] w_pc_next;
  logic [AW-1:0] w_redir_target;
  logic [AW-1:0] w_jtarget;
  logic [31:0]   w_pc4_ext;
  logic [31:0]   w_jfull;
  logic          w_ex_redirect;
  logic          w_id_jump;
  logic          w_busy;
  pcsrc_t        w_pcsrc;

  assign w_ex_redirect = ((ex_op == OP_BEQ) &&  ex_zero) ||
                         ((ex_op == OP_BNE) && !ex_zero) ||
                         ex_jr;
  assign w_redir_target = ex_jr ? ex_jrtarget : ex_btarget;

  assign pc_plus4 = r_pc + AW'(4);

  // Build the jump target at 32 bits so the region slice is legal for any AW.
  assign w_pc4_ext = 32'(pc_plus4);
  assign w_jfull   = {w_pc4_ext[31:28], id_jaddr, 2'b00};
  assign w_jtarget = w_jfull[AW-1:0];

  // Reset forces condep high even if EX shows a redirect.
  assign condep    = rst | ~(w_ex_redirect | w_busy);
  assign w_id_jump = (id_op == OP_J) && condep && !w_ex_redirect;

  always_comb begin
    w_pcsrc   = PCSRC_SEQ;
    w_pc_next = pc_plus4;
    if (w_ex_redirect) begin
      w_pcsrc   = PCSRC_EX;
      w_pc_next = w_redir_target;
    end else if (stall) begin
      w_pcsrc   = PCSRC_HOLD;
      w_pc_next = r_pc;
    end else if (w_id_jump) begin
      w_pcsrc   = PCSRC_JMP;
      w_pc_next = w_jtarget;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= RESET_PC[AW-1:0];
    end else begin
      r_pc <= w_pc_next;
    end
  end

  assign pc    = r_pc;
  assign pcsrc = w_pcsrc;

  pc_flush_ctr #(
    .DEPTH (FLUSH_DEPTH)
  ) u_flush_ctr (
    .clk  (clk),
    .rst  (rst),
    .load (w_ex_redirect),
    .dec  (~stall),
    .busy (w_busy)
  );

`ifdef PC_REDIR_CNT_EN
  logic [15:0] r_redir_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_redir_cnt <= '0;
    end else if (w_ex_redirect && (r_redir_cnt != 16'hFFFF)) begin
      r_redir_cnt <= r_redir_cnt + 16'd1;
    end
  end

  assign redir_cnt = r_redir_cnt;
`endif

endmodule

`default_nettype wire

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL take parameter AW, default 32, giving the PC width; legal range 28..32.
REQ-002 SHALL take parameter FLUSH_DEPTH, default 2, giving the squash cycles after an EX redirect; legal range 1..7.
REQ-003 SHALL take parameter RESET_PC, default 0, giving the PC value loaded at reset; word aligned.
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit, reset; synchronous and active-high.
REQ-006 SHALL have port stall, input, 1 bit; holds the PC when high.
REQ-007 SHALL have port id_op, input, 6 bits; opcode in ID.
REQ-008 SHALL have port id_jaddr, input, 26 bits; J-format target field in ID.
REQ-009 SHALL have ports ex_op (input, 6 bits) and ex_zero (input, 1 bit); opcode and ALU zero flag in EX.
REQ-010 SHALL have port ex_jr, input, 1 bit; jump-register in EX.
REQ-011 SHALL have ports ex_btarget and ex_jrtarget, inputs, AW bits each; branch target and register target from EX.
REQ-012 SHALL have port pc, output, AW bits; registered fetch address.
REQ-013 SHALL have port pc_plus4, output, AW bits; combinational pc+4.
REQ-014 SHALL have port pcsrc, output, 2 bits; next-PC select: 00 seq, 10 EX redirect, 11 ID jump, 01 hold.
REQ-015 SHALL have port condep, output, 1 bit; high when the fetched/ID instruction is valid, low when squashed.

Function
REQ-016 SHALL raise ex_redirect when (ex_op==000100 and ex_zero) or (ex_op==000101 and !ex_zero) or ex_jr.
REQ-017 SHALL set the redirect target to ex_jrtarget when ex_jr is high, else to ex_btarget.
REQ-018 SHALL raise id_jump when id_op==000010, condep is high and ex_redirect is low.
REQ-019 SHALL form the jump target as {pc_plus4[AW-1:28], id_jaddr, 2'b00}, truncated to AW bits.
REQ-020 SHALL resolve next-PC priority as ex_redirect (10) > stall (01) > id_jump (11) > sequential (00), so a redirect overrides stall.
REQ-021 SHALL load the next PC into pc every cycle that rst is low.
REQ-022 SHALL load a flush counter with FLUSH_DEPTH on ex_redirect; otherwise it SHALL decrement while nonzero and not stalled, holding while stalled.
REQ-023 SHALL drive condep low combinationally in the redirect cycle and while the counter is nonzero, and high otherwise.
REQ-024 SHALL reload the counter to FLUSH_DEPTH on a redirect arriving mid-flush, not accumulate it.
REQ-025 SHALL wrap pc+4 modulo 2^AW without flagging.

Reset
REQ-026 SHALL, while rst is high, set pc to RESET_PC, the counter to 0 and condep to 1, regardless of any other input.
REQ-027 SHALL give rst priority over a redirect in the same cycle, and fetch RESET_PC on the first cycle after rst falls.

Configuration
REQ-028 SHALL, with PC_REDIR_CNT_EN defined, add output redir_cnt (16 bits), a counter of ex_redirect cycles that saturates at FFFF and is cleared by rst.
REQ-029 SHALL, without PC_REDIR_CNT_EN, omit both the redir_cnt port and its logic.

Structure
REQ-030 SHALL keep opcode constants (OP_J=000010, OP_BEQ=000100, OP_BNE=000101) and the pcsrc encodings in the shared package cpu_pkg.
REQ-031 SHALL put the flush counter in one sub-module, pc_flush_ctr, with ports load, dec, busy; the rest stays flat.

Verification
REQ-032 Reset: rst high for 2 cycles with RESET_PC=0x100 -> pc=0x100, condep=1; then free-run -> 0x104, 0x108.
REQ-033 BEQ taken: ex_op=000100, ex_zero=1, ex_btarget=0x40 -> pcsrc=10, next pc=0x40, condep low for 1+FLUSH_DEPTH cycles.
REQ-034 BNE not taken plus jump: ex_op=000101, ex_zero=1, id_op=000010, id_jaddr=0x10 -> pcsrc=11, pc=0x40 | upper bits of pc_plus4.
REQ-035 Redirect under stall: stall=1, ex_jr=1, ex_jrtarget=0x200 -> pc=0x200 next cycle; counter holds while stall stays high.
REQ-036 Back-to-back redirects: second redirect on flush cycle 1 -> counter reloads to FLUSH_DEPTH; ID jump during flush is ignored.
REQ-037 Wrap and counter: pc=0xFFFFFFFC -> 0x00000000; with PC_REDIR_CNT_EN, 70000 redirects -> redir_cnt=FFFF.
